// File: rtl/ingress_byte_counter.sv
// ingress_byte_counter
// Registered one-cycle pass-through of the upstream word stream. It watches for
// IO-queue module header words at the start of each packet and adds the header
// byte length to a per-MAC-queue counter (src ports 0/2/4/6 -> q0..q3).
// Optional build macro INGRESS_BYTE_COUNTER_PKT_CNT_EN adds per-queue packet
// counters; without it the packet counter outputs are tied to zero.

module ingress_byte_counter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
  parameter logic [CTRL_WIDTH-1:0] IOQ_HDR_CTRL = CTRL_WIDTH'(8'hFF)
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,

  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,

  input  logic                  clear,

  output logic [31:0]           q0_num_bytes_pushed,
  output logic [31:0]           q1_num_bytes_pushed,
  output logic [31:0]           q2_num_bytes_pushed,
  output logic [31:0]           q3_num_bytes_pushed,

  output logic [31:0]           q0_num_pkts_pushed,
  output logic [31:0]           q1_num_pkts_pushed,
  output logic [31:0]           q2_num_pkts_pushed,
  output logic [31:0]           q3_num_pkts_pushed
);

  localparam int unsigned CNT_W    = 32;
  localparam int unsigned NUM_Q    = 4;
  localparam int unsigned QIDX_W   = 2;
  localparam int unsigned LEN_W    = 16;
  localparam int unsigned PORT_W   = 16;
  localparam int unsigned LEN_LSB  = 0;
  localparam int unsigned PORT_LSB = 16;

  typedef enum logic [0:0] {
    ST_HDR     = 1'b0,
    ST_PAYLOAD = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e                  state_q, state_d;

  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [CTRL_WIDTH-1:0]   out_ctrl_q, out_ctrl_d;
  logic                    out_wr_q,   out_wr_d;

  logic [NUM_Q-1:0][CNT_W-1:0] bytes_q, bytes_d;

  // Header decode results for the word currently on the input
  logic [LEN_W-1:0]        hdr_len;
  logic [PORT_W-1:0]       hdr_port;
  logic                    hdr_accept;
  logic                    q_hit;
  logic [QIDX_W-1:0]       q_idx;

  // Backpressure is passed straight through; this block never stalls
  assign in_rdy = out_rdy;

  assign out_data = out_data_q;
  assign out_ctrl = out_ctrl_q;
  assign out_wr   = out_wr_q;

  // ---------------------------------------------------------------------------
  // Packet framing FSM
  // ---------------------------------------------------------------------------

  // State register; reset abandons any packet in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_HDR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: ctrl==0 words are packet body, a nonzero ctrl in the body is the last word
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HDR: begin
        if (in_wr && (in_ctrl == '0)) begin
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (in_wr && (in_ctrl != '0)) begin
          state_d = ST_HDR;
        end
      end
      default: begin
        state_d = ST_HDR;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Header decode and queue select
  // ---------------------------------------------------------------------------

  // Only IO-queue headers seen before the packet body are decoded
  always_comb begin
    hdr_len    = in_data[LEN_LSB  +: LEN_W];
    hdr_port   = in_data[PORT_LSB +: PORT_W];
    hdr_accept = in_wr && (state_q == ST_HDR) && (in_ctrl == IOQ_HDR_CTRL);
    q_hit      = 1'b0;
    q_idx      = '0;
    case (hdr_port)
      PORT_W'(0): begin
        q_hit = hdr_accept;
        q_idx = QIDX_W'(0);
      end
      PORT_W'(2): begin
        q_hit = hdr_accept;
        q_idx = QIDX_W'(1);
      end
      PORT_W'(4): begin
        q_hit = hdr_accept;
        q_idx = QIDX_W'(2);
      end
      PORT_W'(6): begin
        q_hit = hdr_accept;
        q_idx = QIDX_W'(3);
      end
      default: begin
        q_hit = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // One-cycle registered pass-through
  // ---------------------------------------------------------------------------

  // Next values are the raw input word; clear has no effect here
  always_comb begin
    out_data_d = in_data;
    out_ctrl_d = in_ctrl;
    out_wr_d   = in_wr;
  end

  // Output stage registers, zeroed while in reset
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q <= '0;
      out_ctrl_q <= '0;
      out_wr_q   <= 1'b0;
    end else begin
      out_data_q <= out_data_d;
      out_ctrl_q <= out_ctrl_d;
      out_wr_q   <= out_wr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Byte counters
  // ---------------------------------------------------------------------------

  // Clear takes priority over a header in the same cycle; adds wrap modulo 2^32
  always_comb begin
    bytes_d = bytes_q;
    if (clear) begin
      bytes_d = '0;
    end else if (q_hit) begin
      bytes_d[q_idx] = bytes_q[q_idx] + CNT_W'(hdr_len);
    end
  end

  // Byte counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      bytes_q <= '0;
    end else begin
      bytes_q <= bytes_d;
    end
  end

  assign q0_num_bytes_pushed = bytes_q[0];
  assign q1_num_bytes_pushed = bytes_q[1];
  assign q2_num_bytes_pushed = bytes_q[2];
  assign q3_num_bytes_pushed = bytes_q[3];

  // ---------------------------------------------------------------------------
  // Packet counters (optional)
  // ---------------------------------------------------------------------------
`ifdef INGRESS_BYTE_COUNTER_PKT_CNT_EN

  logic [NUM_Q-1:0][CNT_W-1:0] pkts_q, pkts_d;

  // Same clear priority and wrap behaviour as the byte counters; zero-length headers still count
  always_comb begin
    pkts_d = pkts_q;
    if (clear) begin
      pkts_d = '0;
    end else if (q_hit) begin
      pkts_d[q_idx] = pkts_q[q_idx] + CNT_W'(1);
    end
  end

  // Packet counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pkts_q <= '0;
    end else begin
      pkts_q <= pkts_d;
    end
  end

  assign q0_num_pkts_pushed = pkts_q[0];
  assign q1_num_pkts_pushed = pkts_q[1];
  assign q2_num_pkts_pushed = pkts_q[2];
  assign q3_num_pkts_pushed = pkts_q[3];

`else

  assign q0_num_pkts_pushed = '0;
  assign q1_num_pkts_pushed = '0;
  assign q2_num_pkts_pushed = '0;
  assign q3_num_pkts_pushed = '0;

`endif

endmodule

// File: tb/tb_ingress_byte_counter.sv
// Directed bench for ingress_byte_counter: a scoreboard queue holds every
// accepted input word and is popped as words emerge one cycle later; a small
// reference model tracks the expected per-queue counters.

module tb_ingress_byte_counter;

  localparam int unsigned DW = 64;
  localparam int unsigned CW = DW / 8;
  localparam logic [CW-1:0] HDR = 8'hFF;
`ifdef INGRESS_BYTE_COUNTER_PKT_CNT_EN
  localparam logic PKT_EN = 1'b1;
`else
  localparam logic PKT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          in_wr;
  logic          in_rdy;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          out_wr;
  logic          out_rdy;
  logic          clear;
  logic [31:0]   q0_b, q1_b, q2_b, q3_b;
  logic [31:0]   q0_p, q1_p, q2_p, q3_p;

  logic [31:0]   obs_bytes [4];
  logic [31:0]   obs_pkts  [4];

  assign obs_bytes[0] = q0_b;
  assign obs_bytes[1] = q1_b;
  assign obs_bytes[2] = q2_b;
  assign obs_bytes[3] = q3_b;
  assign obs_pkts[0]  = q0_p;
  assign obs_pkts[1]  = q1_p;
  assign obs_pkts[2]  = q2_p;
  assign obs_pkts[3]  = q3_p;

  always #5 clk = ~clk;

  ingress_byte_counter dut (
    .clk                 (clk),
    .reset               (reset),
    .in_data             (in_data),
    .in_ctrl             (in_ctrl),
    .in_wr               (in_wr),
    .in_rdy              (in_rdy),
    .out_data            (out_data),
    .out_ctrl            (out_ctrl),
    .out_wr              (out_wr),
    .out_rdy             (out_rdy),
    .clear               (clear),
    .q0_num_bytes_pushed (q0_b),
    .q1_num_bytes_pushed (q1_b),
    .q2_num_bytes_pushed (q2_b),
    .q3_num_bytes_pushed (q3_b),
    .q0_num_pkts_pushed  (q0_p),
    .q1_num_pkts_pushed  (q1_p),
    .q2_num_pkts_pushed  (q2_p),
    .q3_num_pkts_pushed  (q3_p)
  );

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } word_t;

  word_t       sb_q [$];
  logic [31:0] m_bytes [4];
  logic [31:0] m_pkts  [4];
  logic        m_payload;
  int          n_checks = 0;
  int          n_pass   = 0;

  // One comparison: counts it, and reports tag/observed/expected on a miss
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Src port to queue index; -1 for ports that map to no queue
  function automatic int port_to_q(input logic [15:0] port);
    case (port)
      16'd0:   return 0;
      16'd2:   return 1;
      16'd4:   return 2;
      16'd6:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [DW-1:0] hdr_word(input logic [15:0] port, input logic [15:0] len);
    return {32'($urandom), port, len};
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    return {32'($urandom), 32'($urandom)};
  endfunction

  // Drive one cycle of stimulus, update the model, then check the output stage
  task automatic drive(input logic wr, input logic [CW-1:0] ctrl, input logic [DW-1:0] data,
                       input logic clr);
    int    qi;
    logic  rst_now;
    word_t w;
    in_wr   = wr;
    in_ctrl = ctrl;
    in_data = data;
    clear   = clr;
    rst_now = reset;
    if (rst_now) begin
      m_payload = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_bytes[i] = '0;
        m_pkts[i]  = '0;
      end
    end else begin
      if (wr) sb_q.push_back({ctrl, data});
      qi = port_to_q(data[31:16]);
      if (clr) begin
        for (int i = 0; i < 4; i++) begin
          m_bytes[i] = '0;
          m_pkts[i]  = '0;
        end
      end else if (wr && !m_payload && (ctrl == HDR) && (qi >= 0)) begin
        m_bytes[qi] = m_bytes[qi] + 32'(data[15:0]);
        m_pkts[qi]  = m_pkts[qi] + 32'(PKT_EN);
      end
      if (wr) m_payload = (ctrl == '0);
    end
    @(posedge clk);
    #1;
    chk("out_wr", 64'(out_wr), 64'(wr & ~rst_now));
    if (rst_now) begin
      chk("rst_out_data", out_data, '0);
      chk("rst_out_ctrl", 64'(out_ctrl), '0);
    end else if (out_wr) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $error("FAIL sb_underflow: observed out_wr=1 expected no pending word");
      end else begin
        w = sb_q.pop_front();
        chk("out_data", out_data, w.data);
        chk("out_ctrl", 64'(out_ctrl), 64'(w.ctrl));
      end
    end
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0);
  endtask

  // Compare all eight counters against the model
  task automatic check_counters();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("q%0d_bytes", i), 64'(obs_bytes[i]), 64'(m_bytes[i]));
      chk($sformatf("q%0d_pkts", i),  64'(obs_pkts[i]),  64'(m_pkts[i]));
    end
  endtask

  initial begin
    reset   = 1'b1;
    clear   = 1'b0;
    in_wr   = 1'b0;
    in_ctrl = '0;
    in_data = '0;
    out_rdy = 1'b1;

    // Reset state, with traffic present during reset
    drive(1'b1, 8'h12, 64'hDEAD_BEEF_0123_4567, 1'b0);
    drive(1'b0, '0, '0, 1'b0);
    check_counters();
    reset = 1'b0;

    // Ready is a combinational copy of downstream ready
    out_rdy = 1'b0;
    #1;
    chk("in_rdy_low", 64'(in_rdy), 64'(0));
    out_rdy = 1'b1;
    #1;
    chk("in_rdy_high", 64'(in_rdy), 64'(1));

    // Port-2 header, length 0x40, then 8 body words
    drive(1'b1, HDR, hdr_word(16'd2, 16'h0040), 1'b0);
    chk("q1_bytes_hdr", 64'(q1_b), 64'h40);
    chk("q0_bytes_zero", 64'(q0_b), 64'h0);
    chk("q2_bytes_zero", 64'(q2_b), 64'h0);
    chk("q3_bytes_zero", 64'(q3_b), 64'h0);
    check_counters();
    for (int i = 0; i < 8; i++) drive(1'b1, (i == 7) ? 8'h80 : 8'h00, rnd_word(), 1'b0);
    idle();
    chk("sb_drained_1", 64'(sb_q.size()), 64'(0));

    // Unmapped src port: packet passes, no counter moves
    drive(1'b1, HDR, hdr_word(16'd1, 16'd100), 1'b0);
    chk("q1_bytes_port1", 64'(q1_b), 64'h40);
    check_counters();
    drive(1'b1, 8'h00, rnd_word(), 1'b0);
    drive(1'b1, 8'h80, rnd_word(), 1'b0);
    idle();

    // IOQ header inside the body is ignored (and ends the packet)
    drive(1'b1, HDR, hdr_word(16'd4, 16'd8), 1'b0);
    chk("q2_bytes_8", 64'(q2_b), 64'd8);
    drive(1'b1, 8'h00, rnd_word(), 1'b0);
    drive(1'b1, HDR, hdr_word(16'd0, 16'd5), 1'b0);
    chk("q0_bytes_body_hdr", 64'(q0_b), 64'd0);
    check_counters();

    // Non-IOQ module header is not decoded; then a zero-length header
    drive(1'b1, 8'h01, hdr_word(16'd0, 16'd7), 1'b0);
    chk("q0_bytes_other_hdr", 64'(q0_b), 64'd0);
    drive(1'b1, HDR, hdr_word(16'd6, 16'd0), 1'b0);
    chk("q3_bytes_len0", 64'(q3_b), 64'd0);
    chk("q3_pkts_len0", 64'(q3_p), 64'(PKT_EN));
    drive(1'b1, 8'h00, rnd_word(), 1'b0);
    drive(1'b1, 8'h80, rnd_word(), 1'b0);
    check_counters();

    // Clear wins over a same-cycle header; the next header counts
    drive(1'b1, HDR, hdr_word(16'd4, 16'd64), 1'b1);
    chk("q2_bytes_clear", 64'(q2_b), 64'd0);
    check_counters();
    drive(1'b1, HDR, hdr_word(16'd4, 16'd64), 1'b0);
    chk("q2_bytes_after_clear", 64'(q2_b), 64'd64);
    chk("q2_pkts_after_clear", 64'(q2_p), 64'(PKT_EN));
    drive(1'b1, 8'h00, rnd_word(), 1'b0);
    drive(1'b1, 8'h04, rnd_word(), 1'b0);
    idle();

    // Preload q0 to 0xFFFFFFF0 with back-to-back headers, then wrap it
    drive(1'b0, '0, '0, 1'b1);
    check_counters();
    for (int i = 0; i < 65536; i++) drive(1'b1, HDR, hdr_word(16'd0, 16'hFFFF), 1'b0);
    drive(1'b1, HDR, hdr_word(16'd0, 16'hFFF0), 1'b0);
    chk("q0_bytes_preload", 64'(q0_b), 64'hFFFF_FFF0);
    drive(1'b1, HDR, hdr_word(16'd0, 16'h0020), 1'b0);
    chk("q0_bytes_wrap", 64'(q0_b), 64'h10);
    check_counters();
    drive(1'b1, 8'h00, rnd_word(), 1'b0);
    drive(1'b1, 8'h80, rnd_word(), 1'b0);
    idle();

    // Reset mid-packet; the next word is parsed as a header
    drive(1'b1, HDR, hdr_word(16'd2, 16'd1), 1'b0);
    drive(1'b1, 8'h00, rnd_word(), 1'b0);
    reset = 1'b1;
    drive(1'b1, 8'h00, rnd_word(), 1'b0);
    check_counters();
    reset = 1'b0;
    drive(1'b1, HDR, hdr_word(16'd6, 16'd60), 1'b0);
    chk("q3_bytes_after_rst", 64'(q3_b), 64'd60);
    chk("q3_pkts_after_rst", 64'(q3_p), 64'(PKT_EN));
    drive(1'b1, 8'h00, rnd_word(), 1'b0);
    drive(1'b1, 8'h80, rnd_word(), 1'b0);
    idle();
    idle();
    chk("sb_drained_end", 64'(sb_q.size()), 64'(0));
    check_counters();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
